// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared types, funct3 encodings and size decode for the MEM-stage LSU
package mem_stage_lsu_pkg;

    localparam int LSU_XLEN = 32;
    localparam int LSU_BE_W = LSU_XLEN / 8;

    // funct3 encodings shared by loads and stores (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RESP,
        LSU_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    typedef struct packed {
        logic                we;
        logic [2:0]          funct3;
        logic [LSU_XLEN-1:0] addr;
        logic [LSU_XLEN-1:0] wdata;
    } lsu_req_t;

    // Encodings 011/110/111 have no byte/half meaning and fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// rtl/mem_stage_lsu_load_align.sv - combinational load data lane select and sign/zero extension
// Ports:
//   rdata_i   : raw word returned by data memory
//   addr_lo_i : byte offset of the access within the word
//   funct3_i  : load size/sign encoding
//   data_o    : lane-aligned, extended load result
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        zext;

    always_comb begin
        zext   = (funct3_i == F3_BU) || (funct3_i == F3_HU);
        byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Halfwords select on addr[1] only; an odd address reads the enclosing aligned half.
        half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        data_o = rdata_i;
        case (lsu_size(funct3_i))
            SZ_B:    data_o = {{(XLEN-8){~zext & byte_v[7]}}, byte_v};
            SZ_H:    data_o = {{(XLEN-16){~zext & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a req/gnt/rvalid data-memory port
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses skip memory and raise misalign_o)
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   req_valid_i/read/write/funct3   : memory operation from the EX/MEM register
//   req_addr_i, req_wdata_i         : byte address and store data
//   stall_o                         : freeze pipeline registers while the access is in flight
//   load_valid_o, load_data_o       : formatted load result, valid in the DONE cycle
//   dmem_req/we/be/addr/wdata_o     : request side of the data-memory port
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i : response side of the data-memory port
//   misalign_o                      : misaligned access flag (only with LSU_MISALIGN_TRAP_EN)
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int BE_W = LSU_BE_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_i,
    input  logic            req_read_i,
    input  logic            req_write_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            stall_o,
    output logic            load_valid_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [BE_W-1:0] dmem_be_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [XLEN-1:0] aligned_rdata;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata_fmt;
    logic            start;

    // A valid with neither read nor write set is not a memory operation and is never captured.
    assign start = req_valid_i & (req_read_i | req_write_i);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic misaligned_new;

    always_comb begin
        misaligned_new = 1'b0;
        case (lsu_size(req_funct3_i))
            SZ_H:    misaligned_new = req_addr_i[0];
            SZ_W:    misaligned_new = |req_addr_i[1:0];
            default: misaligned_new = 1'b0;
        endcase
    end
`endif

    mem_stage_lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata_i   (dmem_rdata_i),
        .addr_lo_i (req_q.addr[1:0]),
        .funct3_i  (req_q.funct3),
        .data_o    (aligned_rdata)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    // Write wins when both read and write are flagged.
                    req_d.we     = req_write_i;
                    req_d.funct3 = req_funct3_i;
                    req_d.addr   = req_addr_i;
                    req_d.wdata  = req_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned_new) begin
                        state_d    = LSU_DONE;
                        misalign_d = 1'b1;
                        if (!req_write_i) begin
                            load_data_d = '0;
                        end
                    end else begin
                        state_d = LSU_REQ;
                    end
`else
                    state_d = LSU_REQ;
`endif
                end
            end
            LSU_REQ: begin
                if (dmem_gnt_i) begin
                    state_d = req_q.we ? LSU_DONE : LSU_WAIT_RESP;
                end
            end
            LSU_WAIT_RESP: begin
                if (dmem_rvalid_i) begin
                    load_data_d = aligned_rdata;
                    state_d     = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            req_q       <= '0;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Store lane enables and lane-replicated data, derived from the captured request so
    // they stay stable for the whole REQ phase regardless of pipeline inputs.
    always_comb begin
        be        = '0;
        wdata_fmt = req_q.wdata;
        case (lsu_size(req_q.funct3))
            SZ_B: begin
                be        = BE_W'(4'b0001) << req_q.addr[1:0];
                wdata_fmt = {(XLEN/8){req_q.wdata[7:0]}};
            end
            SZ_H: begin
                be        = BE_W'(4'b0011) << {req_q.addr[1], 1'b0};
                wdata_fmt = {(XLEN/16){req_q.wdata[15:0]}};
            end
            default: begin
                be        = '1;
                wdata_fmt = req_q.wdata;
            end
        endcase
    end

    assign dmem_req_o   = (state_q == LSU_REQ);
    assign dmem_we_o    = dmem_req_o & req_q.we;
    assign dmem_be_o    = dmem_req_o ? be : '0;
    assign dmem_addr_o  = {req_q.addr[XLEN-1:2], 2'b00};
    assign dmem_wdata_o = wdata_fmt;

    // Stall in the request cycle itself; release only in DONE so the pipeline advances once.
    assign stall_o     = req_valid_i & (state_q != LSU_DONE);
    assign load_data_o = load_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o   = (state_q == LSU_DONE) & misalign_q;
    assign load_valid_o = (state_q == LSU_DONE) & ~req_q.we & ~misalign_q;
`else
    assign load_valid_o = (state_q == LSU_DONE) & ~req_q.we;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard testbench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_i, req_read_i, req_write_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        stall_o, load_valid_o;
    logic [31:0] load_data_o;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_stage_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_read_i    (req_read_i),
        .req_write_i   (req_write_i),
        .req_funct3_i  (req_funct3_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .stall_o       (stall_o),
        .load_valid_o  (load_valid_o),
        .load_data_o   (load_data_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } exp_req_t;

    exp_req_t    exp_req_q[$];
    logic [31:0] exp_load_q[$];
    logic [31:0] last_load = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event", name);
    endtask

    // Monitor: every request cycle is compared against the head of the request queue
    // (so the request must stay stable until granted); every load_valid pops a load.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req_o) begin
                if (exp_req_q.size() == 0) begin
                    flag_fail("req_unexpected");
                end else begin
                    exp_req_t e;
                    e = exp_req_q[0];
                    check("req_addr", dmem_addr_o, e.addr);
                    check("req_be", {28'h0, dmem_be_o}, {28'h0, e.be});
                    check("req_wdata", dmem_wdata_o, e.wdata);
                    check("req_we", {31'h0, dmem_we_o}, {31'h0, e.we});
                    if (dmem_gnt_i) void'(exp_req_q.pop_front());
                end
            end
            if (load_valid_o) begin
                if (exp_load_q.size() == 0) flag_fail("load_unexpected");
                else check("load_data", load_data_o, exp_load_q.pop_front());
            end
        end
    end

    // One access: memory grants after gd request cycles and returns data rdl cycles after
    // the earliest legal rvalid cycle. spur drives a junk rvalid while the request waits.
    task automatic do_access(input bit wr, input bit rd, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int gd, input int rdl,
                             input bit spur, input logic [3:0] ebe,
                             input logic [31:0] ewd, input logic [31:0] eld,
                             input int est, input string name);
        int  req_cnt, wait_cnt, stalls;
        bit  waiting, done, real_rv;
        exp_req_t e;
        e = '{addr & 32'hFFFF_FFFC, ebe, ewd, wr};
        exp_req_q.push_back(e);
        if (!wr) begin
            exp_load_q.push_back(eld);
            last_load = eld;
        end
        @(posedge clk); #1;
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        req_read_i   = rd;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_cnt = 0; wait_cnt = 0; stalls = 0; waiting = 0; done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            dmem_gnt_i = dmem_req_o && (req_cnt == gd);
            if (dmem_req_o) req_cnt++;
            real_rv       = waiting && (wait_cnt == rdl);
            dmem_rdata_i  = real_rv ? rdata : 32'hBAD0_BAD0;
            dmem_rvalid_i = real_rv || (spur && dmem_req_o && !dmem_gnt_i);
            if (waiting) wait_cnt++;
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1;
            if (real_rv) waiting = 0;
            if (dmem_req_o && dmem_gnt_i && !wr) begin
                waiting  = 1;
                wait_cnt = 0;
            end
            @(posedge clk); #1;
        end
        if (!done) flag_fail({name, "_timeout"});
        check({name, "_stall_cycles"}, stalls, est);
        req_valid_i   = 1'b0;
        req_read_i    = 1'b0;
        req_write_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid_i = 1'b0; req_read_i = 1'b0; req_write_i = 1'b0;
        req_funct3_i = 3'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_load_valid", {31'h0, load_valid_o}, 32'h0);
        check("rst_load_data", load_data_o, 32'h0);
        check("rst_dmem_req", {31'h0, dmem_req_o}, 32'h0);
        check("rst_dmem_we", {31'h0, dmem_we_o}, 32'h0);
        check("rst_dmem_be", {28'h0, dmem_be_o}, 32'h0);
        check("rst_dmem_addr", dmem_addr_o, 32'h0);
        check("rst_dmem_wdata", dmem_wdata_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //        wr rd f3      addr          wdata          rdata         gd rdl sp be       ewd            eld            st
        do_access(1, 0, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2, "sw");
        do_access(1, 0, 3'b000, 32'h103, 32'h0000_00A5, 32'h0,         0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0,         2, "sb");
        do_access(1, 0, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0,         1, 0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,         3, "sh_gnt1");
        do_access(0, 1, 3'b000, 32'h102, 32'h0,         32'h0080_0000, 0, 0, 0, 4'b0100, 32'h0,         32'hFFFF_FF80, 3, "lb");
        do_access(0, 1, 3'b100, 32'h102, 32'h0,         32'h0080_0000, 0, 0, 0, 4'b0100, 32'h0,         32'h0000_0080, 3, "lbu");
        do_access(0, 1, 3'b001, 32'h102, 32'h0,         32'h8001_0000, 2, 3, 1, 4'b1100, 32'h0,         32'hFFFF_8001, 8, "lh_slow");
        do_access(0, 1, 3'b101, 32'h102, 32'h0,         32'h8001_0000, 0, 0, 0, 4'b1100, 32'h0,         32'h0000_8001, 3, "lhu");
        do_access(0, 1, 3'b010, 32'h108, 32'h0,         32'hCAFE_F00D, 0, 1, 0, 4'b1111, 32'h0,         32'hCAFE_F00D, 4, "lw_rv1");
        do_access(0, 1, 3'b011, 32'h10C, 32'h0,         32'h0123_4567, 0, 0, 0, 4'b1111, 32'h0,         32'h0123_4567, 3, "ld_f3_011");
        do_access(0, 1, 3'b000, 32'h101, 32'h0,         32'h0000_7F00, 0, 0, 0, 4'b0010, 32'h0,         32'h0000_007F, 3, "lb_pos");
        do_access(0, 1, 3'b100, 32'h103, 32'h0,         32'hF000_0000, 0, 0, 0, 4'b1000, 32'h0,         32'h0000_00F0, 3, "lbu_b3");
`ifndef LSU_MISALIGN_TRAP_EN
        do_access(0, 1, 3'b001, 32'h103, 32'h0,         32'h8001_7FFF, 0, 0, 0, 4'b1100, 32'h0,         32'hFFFF_8001, 3, "lh_mis");
        do_access(1, 0, 3'b010, 32'h107, 32'h1122_3344, 32'h0,         0, 0, 0, 4'b1111, 32'h1122_3344, 32'h0,         2, "sw_mis");
`endif
        do_access(1, 1, 3'b000, 32'h111, 32'h0000_00C3, 32'h0,         0, 0, 0, 4'b0010, 32'hC3C3_C3C3, 32'h0,         2, "sb_rdwr");
        do_access(1, 0, 3'b111, 32'h118, 32'h89AB_CDEF, 32'h0,         0, 0, 0, 4'b1111, 32'h89AB_CDEF, 32'h0,         2, "st_f3_111");
        @(negedge clk);
        check("load_data_hold", load_data_o, last_load);

`ifdef LSU_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_read_i = 1'b1; req_write_i = 1'b0;
        req_funct3_i = 3'b010; req_addr_i = 32'h101; req_wdata_i = 32'h0;
        @(negedge clk);
        check("mis_stall_idle", {31'h0, stall_o}, 32'h1);
        check("mis_no_req_idle", {31'h0, dmem_req_o}, 32'h0);
        @(negedge clk);
        check("mis_stall_done", {31'h0, stall_o}, 32'h0);
        check("mis_flag", {31'h0, misalign_o}, 32'h1);
        check("mis_no_req_done", {31'h0, dmem_req_o}, 32'h0);
        check("mis_load_data", load_data_o, 32'h0);
        check("mis_load_valid", {31'h0, load_valid_o}, 32'h0);
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_read_i = 1'b0;
`endif

        // Reset while waiting for read data: the late rvalid must be dropped.
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_read_i = 1'b1; req_write_i = 1'b0;
        req_funct3_i = 3'b010; req_addr_i = 32'h200; req_wdata_i = 32'h0;
        exp_req_q.push_back('{32'h200, 4'b1111, 32'h0, 1'b0});
        @(posedge clk); #1;
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0; rst_n = 1'b0; req_valid_i = 1'b0; req_read_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55AA_55AA;
        @(negedge clk);
        check("rstmid_load_valid_a", {31'h0, load_valid_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_load_valid_b", {31'h0, load_valid_o}, 32'h0);
        check("rstmid_dmem_req", {31'h0, dmem_req_o}, 32'h0);
        check("rstmid_addr_cleared", dmem_addr_o, 32'h0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rstmid_load_valid_c", {31'h0, load_valid_o}, 32'h0);
        check("rstmid_load_data", load_data_o, 32'h0);
        check("rstmid_req_consumed", exp_req_q.size(), 0);

        do_access(0, 1, 3'b010, 32'h204, 32'h0, 32'h1357_9BDF, 0, 0, 0, 4'b1111, 32'h0, 32'h1357_9BDF, 3, "lw_after_rst");

        repeat (3) @(negedge clk);
        check("req_queue_empty", exp_req_q.size(), 0);
        check("load_queue_empty", exp_load_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
